// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: PC generation, credit-limited imem requests, in-order
// response buffering with PCs, and redirect flush with stale-response dropping.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;
  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  cnt_t        outstanding_q, outstanding_d;
  cnt_t        drop_q, drop_d;
  cnt_t        count_q, count_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        pcq_wr_q, pcq_wr_d;
  ptr_t        pcq_rd_q, pcq_rd_d;

  logic [31:0] fifo_instr_q [DEPTH];
  logic [31:0] fifo_pc_q    [DEPTH];
  logic [31:0] pcq_q        [DEPTH];

  logic [CW+1:0] used;
  logic          has_credit;
  logic          accept;
  logic          resp_any;
  logic          resp_drop;
  logic          resp_keep;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_target;

  // Credit counts every slot that a response could still land in, so the FIFO
  // can never overflow even if decode stalls with requests in flight.
  assign used       = {2'b00, count_q} + {2'b00, outstanding_q} + {2'b00, drop_q};
  assign has_credit = used < (CW + 2)'(DEPTH);

  assign imem_req  = !reset && !redirect && has_credit;
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_gnt;

  assign resp_any  = imem_rvalid && ((drop_q != '0) || (outstanding_q != '0));
  assign resp_drop = imem_rvalid && (drop_q != '0);
  assign resp_keep = imem_rvalid && (drop_q == '0) && (outstanding_q != '0);

  assign push = resp_keep && !redirect;
  assign instr_valid = count_q != '0;
  assign pop  = instr_valid && instr_ready && !redirect;

  assign redirect_target = redirect_pc & ~32'h0000_0003;

  // Gate the head so an empty FIFO presents zeros rather than stale entries.
  assign instr    = instr_valid ? fifo_instr_q[rd_ptr_q] : '0;
  assign instr_pc = instr_valid ? fifo_pc_q[rd_ptr_q]    : '0;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pcq_wr_d      = pcq_wr_q;
    pcq_rd_d      = pcq_rd_q;

    if (redirect) begin
      fetch_pc_d    = redirect_target;
      drop_d        = drop_q + outstanding_q - cnt_t'(resp_any);
      outstanding_d = '0;
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      pcq_wr_d      = '0;
      pcq_rd_d      = '0;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        pcq_wr_d   = pcq_wr_q + ptr_t'(1);
      end
      if (resp_drop) drop_d = drop_q - cnt_t'(1);
      if (resp_keep) pcq_rd_d = pcq_rd_q + ptr_t'(1);
      if (push)      wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)       rd_ptr_d = rd_ptr_q + ptr_t'(1);
      outstanding_d = outstanding_q + cnt_t'(accept) - cnt_t'(resp_keep);
      count_d       = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (drop_d != '0) state_d = ST_FLUSH;
      ST_FLUSH: if (drop_d == '0) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pcq_wr_q      <= pcq_wr_d;
      pcq_rd_q      <= pcq_rd_d;
    end
  end

  // NOTE: storage arrays are not reset; the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= pcq_q[pcq_rd_q];
    end
    if (accept) pcq_q[pcq_wr_q] <= fetch_pc_q;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a behavioural memory, a PC-stream model
// fed on each accepted request, and a monitor that checks every consumed instruction.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int gnt_pct = 100;
  int rv_pct = 100;
  int lat = 1;
  int cycle_cnt = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } mem_t;

  exp_t        exp_q[$];
  mem_t        mem_q[$];
  logic [31:0] model_pc = RESET_PC;
  logic        hold_v = 1'b0;
  logic [31:0] hold_pc = '0;
  logic [31:0] hold_word = '0;

  instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    mem_q.delete();
    acc_cnt = 0;
    pop_cnt = 0;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    @(posedge clk);
    #2;
    gnt_pct = 0;
    rv_pct = 100;
    redirect = 1'b0;
    instr_ready = 1'b1;
    cyc(16);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Memory: grants at random, answers in order after at least lat cycles.
  initial forever begin
    @(posedge clk);
    cycle_cnt++;
    #1;
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (mem_q.size() > 0 && cycle_cnt >= mem_q[0].cyc + lat && $urandom_range(99) < rv_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  end

  // Monitor: expected stream is consecutive PCs from the last restart point.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset) begin
      exp_q.delete();
      model_pc = RESET_PC;
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", 32'(instr_valid), 32'd1);
        check("hold_pc", instr_pc, hold_pc);
        check("hold_instr", instr, hold_word);
      end
      if (imem_req && imem_gnt) mem_q.push_back('{word_at(imem_addr), cycle_cnt});
      if (redirect) begin
        check("req_during_redirect", 32'(imem_req), 32'd0);
        exp_q.delete();
        model_pc = redirect_pc & ~32'h3;
      end else begin
        if (instr_valid && instr_ready) begin
          pop_cnt++;
          if (exp_q.size() == 0) begin
            check("instr_without_request", 32'(instr_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("instr_pc", instr_pc, e.pc);
            check("instr_word", instr, e.word);
          end
        end
        if (imem_req && imem_gnt) begin
          acc_cnt++;
          check("req_addr", imem_addr, model_pc);
          exp_q.push_back('{model_pc, word_at(model_pc)});
          model_pc = model_pc + 32'd4;
        end
      end
      hold_v    = instr_valid && !instr_ready && !redirect;
      hold_pc   = instr_pc;
      hold_word = instr;
    end
  end

  initial begin
    // Reset values while reset is held.
    #3;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'd0);

    // Zero-wait stream: first instr_valid in cycle 3, then one per cycle.
    gnt_pct = 100; rv_pct = 100; lat = 1; instr_ready = 1'b1;
    do_reset();
    @(negedge clk);
    check("t1_c1_req", 32'(imem_req), 32'd1);
    check("t1_c1_addr", imem_addr, RESET_PC);
    check("t1_c1_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("t1_c2_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("t1_c3_valid", 32'(instr_valid), 32'd1);
    check("t1_c3_pc", instr_pc, RESET_PC);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t1_stream_valid", 32'(instr_valid), 32'd1);
    end
    drain("t1_drain");

    // Decode stalled: credit caps accepts at DEPTH, head stays put.
    gnt_pct = 100; rv_pct = 100; lat = 1; instr_ready = 1'b0;
    do_reset();
    cyc(9);
    @(negedge clk);
    check("t2_accepts", 32'(acc_cnt), 32'(DEPTH));
    check("t2_valid", 32'(instr_valid), 32'd1);
    check("t2_head_pc", instr_pc, RESET_PC);
    drain("t2_drain");
    check("t2_pops", 32'(pop_cnt), 32'(DEPTH));

    // Ungranted requests hold the address, then slow responses.
    gnt_pct = 0; rv_pct = 100; lat = 4; instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_req_held", 32'(imem_req), 32'd1);
      check("t3_addr_held", imem_addr, RESET_PC);
    end
    @(posedge clk);
    #2;
    gnt_pct = 100;
    cyc(12);
    drain("t3_drain");

    // Redirect with two requests in flight.
    gnt_pct = 100; rv_pct = 100; lat = 6; instr_ready = 1'b1;
    do_reset();
    cyc(1);
    gnt_pct = 0;
    cyc(1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    check("t4_inflight", 32'(acc_cnt), 32'd2);
    check("t4_req_r", 32'(imem_req), 32'd0);
    cyc(1);
    redirect = 1'b0;
    gnt_pct = 100;
    @(negedge clk);
    check("t4_valid_r1", 32'(instr_valid), 32'd0);
    check("t4_req_r1", 32'(imem_req), 32'd1);
    check("t4_addr_r1", imem_addr, 32'h0000_0100);
    cyc(14);
    drain("t4_drain");

    // Redirect coinciding with a pop and a live response.
    gnt_pct = 100; rv_pct = 100; lat = 1; instr_ready = 1'b1;
    do_reset();
    cyc(5);
    redirect = 1'b1;
    redirect_pc = 32'h2000_0007;
    @(negedge clk);
    check("t5_valid_r", 32'(instr_valid), 32'd1);
    check("t5_rvalid_r", 32'(imem_rvalid), 32'd1);
    cyc(1);
    redirect = 1'b0;
    @(negedge clk);
    check("t5_valid_r1", 32'(instr_valid), 32'd0);
    cyc(10);
    drain("t5_drain");

    // Asynchronous reset with three requests outstanding; late responses ignored.
    gnt_pct = 100; rv_pct = 100; lat = 8; instr_ready = 1'b1;
    do_reset();
    cyc(2);
    gnt_pct = 0;
    cyc(1);
    check("t6_inflight", 32'(acc_cnt), 32'd3);
    check("t6_addr_pre", imem_addr, RESET_PC + 32'd12);
    reset = 1'b1;
    #1;
    check("t6_rst_req", 32'(imem_req), 32'd0);
    check("t6_rst_addr", imem_addr, RESET_PC);
    check("t6_rst_valid", 32'(instr_valid), 32'd0);
    check("t6_rst_instr", instr, 32'd0);
    check("t6_rst_pc", instr_pc, 32'd0);
    cyc(2);
    reset = 1'b0;
    cyc(14);
    @(negedge clk);
    check("t6_late_valid", 32'(instr_valid), 32'd0);
    check("t6_restart_addr", imem_addr, RESET_PC);
    cyc(1);
    gnt_pct = 100;
    lat = 1;
    cyc(10);
    drain("t6_drain");

    // Randomized traffic with stalls, variable latency and redirects.
    gnt_pct = 70; rv_pct = 60; lat = 1; instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(99) < 75);
      redirect    = ($urandom_range(99) < 3);
      redirect_pc = $urandom;
      lat         = int'($urandom_range(3, 1));
      cyc(1);
    end
    redirect = 1'b0;
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
